wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Owns the single register-file write port behind the write-back stage.
//  Shares the port between the in-order pipeline W stage and a long-latency unit (LU: mul/div).
//  LU results queue in a small pending FIFO; a starvation counter can steal one W-stage cycle.
//  A per-register busy scoreboard feeds the hazard unit for LU destinations.
// PARAMETERS
//  XLEN      32  data width of results / register file
//  DEPTH      2  pending-queue entries for LU results (power of 2, >=2)
//  MAX_WAIT   4  cycles a blocked queue head may wait before a W-stage stall is forced (>=1)
// PORTS
//  clk            in   1     clock, all state on rising edge
//  srst           in   1     synchronous reset, active-low
//  wb_reg_write_i in   1     W stage wants to write
//  wb_rd_i        in   5     W stage destination
//  wb_result_i    in   XLEN  W stage result (write-back mux output)
//  lu_issue_i     in   1     LU op issued this cycle; mark destination busy
//  lu_issue_rd_i  in   5     destination of issued LU op
//  lu_valid_i     in   1     LU result valid
//  lu_rd_i        in   5     LU result destination
//  lu_data_i      in   XLEN  LU result data
//  lu_ready_o     out  1     arbiter accepts LU result this cycle
//  wb_stall_o     out  1     W stage must hold its contents one cycle (port stolen)
//  rf_we_o        out  1     register-file write enable
//  rf_waddr_o     out  5     register-file write address
//  rf_wdata_o     out  XLEN  register-file write data
//  busy_o         out  32    scoreboard: bit r set = LU write to xr outstanding
// BEHAVIOUR
//  Reset (srst=0 at edge): queue empty, wait_cnt=0, busy_o=0.
//   While srst=0: rf_we_o=0, lu_ready_o=0, wb_stall_o=0.
//  wb_act = wb_reg_write_i && wb_rd_i!=0. Writes to x0 are never driven (rf_we_o=0), but still complete.
//  Port grant per cycle, combinational, zero added latency for W stage:
//   1. wb_stall_o=1            -> queue head written; W stage not written this cycle.
//   2. wb_act                  -> W stage written.
//   3. queue non-empty         -> queue head written (pop).
//   4. queue empty, lu_valid_i -> LU bypass: written same cycle, not enqueued.
//   5. otherwise rf_we_o=0.
//  lu_ready_o = !full, or full && head popped this cycle (simultaneous pop+push allowed).
//   Accepted LU result not written via bypass is pushed at tail. Order strictly FIFO.
//   lu_rd_i==0 accepted and dropped (no push, no write).
//  Starvation counter:
//   wait_cnt increments (saturating at MAX_WAIT) each cycle the queue is non-empty and the head is not written.
//   Cleared on any pop or when empty.
//   wb_stall_o = !empty && wb_act && wait_cnt==MAX_WAIT.
//   Result: head blocked exactly MAX_WAIT cycles, written on the next cycle.
//   Stall lasts one cycle per pop; count restarts for the next head.
//  Scoreboard:
//   lu_issue_i && lu_issue_rd_i!=0 sets busy[rd] at next edge.
//   Any LU write (pop or bypass) to rd clears busy[rd] at next edge.
//   Same rd set and cleared in same cycle -> set wins.
//   W-stage write to a busy rd is illegal (hazard unit stalls on WAW); a bench assertion flags it.
//  No reordering between W stage and LU results for the same rd is performed or required.
// STRUCTURE
//  rv_pkg (shared):
//   localparam REG_AW=5;
//   typedef struct packed {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;} wb_req_t.
//  Sub-module wb_pend_fifo: DEPTH x wb_req_t sync FIFO.
//   Signals: push/pop/full/empty/head; ptr wrap via extra MSB.
//  Top level: grant mux, wait counter, busy register file, reset gating.
// TESTING
//  1 Reset:
//    hold srst=0 3 cycles with all inputs active
//    -> rf_we_o=0, lu_ready_o=0, wb_stall_o=0, busy_o=0; state cleared.
//  2 Bypass:
//    W idle; lu_valid_i=1 rd=5 data=0xDEAD_BEEF
//    -> same cycle rf_we_o=1 waddr=5 wdata=0xDEADBEEF; lu_ready_o=1; busy[5] cleared next edge.
//  3 Priority + queue:
//    W writes x3 every cycle; LU delivers x7=0x11 then x8=0x22
//    -> both queued, lu_ready_o=0 on third; W stage writes continue uninterrupted.
//  4 Starvation (MAX_WAIT=4):
//    W writes continuously with one queued entry
//    -> wb_stall_o=1 on 5th blocked cycle; x7=0x11 written; W held.
//    Then the next head stalls 4 cycles later.
//  5 Full + simultaneous:
//    queue full; W idle; lu_valid_i=1 x9
//    -> pop x7 and push x9 same cycle; lu_ready_o=1; FIFO order x8, x9.
//  6 Scoreboard/x0:
//    issue rd=4 and LU write rd=4 same cycle -> busy[4]=1.
//    issue rd=0 -> busy unchanged.
//    W write x0 -> rf_we_o=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared write-back types: register address width, data width and the
// pending-request record carried from the long-latency unit to the write port.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // One-hot mask over the 32 architectural registers.
    function automatic logic [31:0] reg_mask(input logic [REG_AW-1:0] r);
        return 32'h0000_0001 << r;
    endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Small synchronous FIFO of pending LU write-back requests. Pointers carry an
// extra wrap bit so full and empty are told apart without a counter.
module wb_pend_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    srst,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t       mem_r [DEPTH];
    logic [AW:0]   wptr_r;
    logic [AW:0]   rptr_r;

    // Pointer update and storage write; a push into a full FIFO is only issued
    // together with a pop, so it overwrites the slot being read out.
    always_ff @(posedge clk) begin
        if (!srst) begin
            wptr_r <= {(AW + 1){1'b0}};
            rptr_r <= {(AW + 1){1'b0}};
        end else begin
            if (push) begin
                mem_r[wptr_r[AW-1:0]] <= din;
                wptr_r                <= wptr_r + (AW + 1)'(1);
            end
            if (pop) begin
                rptr_r <= rptr_r + (AW + 1)'(1);
            end
        end
    end

    assign head  = mem_r[rptr_r[AW-1:0]];
    assign empty = (wptr_r == rptr_r);
    assign full  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the W stage and the
// long-latency unit, with a pending queue, starvation stall and busy scoreboard.
module wb_port_arbiter
    import rv_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                wb_reg_write_i,
    input  logic [REG_AW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0]     wb_result_i,
    input  logic                lu_issue_i,
    input  logic [REG_AW-1:0]   lu_issue_rd_i,
    input  logic                lu_valid_i,
    input  logic [REG_AW-1:0]   lu_rd_i,
    input  logic [XLEN-1:0]     lu_data_i,
    output logic                lu_ready_o,
    output logic                wb_stall_o,
    output logic                rf_we_o,
    output logic [REG_AW-1:0]   rf_waddr_o,
    output logic [XLEN-1:0]     rf_wdata_o,
    output logic [31:0]         busy_o
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    wb_req_t             head_s;
    wb_req_t             push_req_s;
    logic                full_s;
    logic                empty_s;
    logic                wb_act_s;
    logic                stall_s;
    logic                pop_s;
    logic                bypass_s;
    logic                push_s;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [31:0]         busy_nxt_s;

    assign wb_act_s   = wb_reg_write_i && (wb_rd_i != 5'd0);
    assign stall_s    = srst && !empty_s && wb_act_s && (wait_cnt_r == WAIT_W'(MAX_WAIT));
    assign wb_stall_o = stall_s;

    // Port grant: stolen cycle, then W stage, then queue head, then LU bypass.
    always_comb begin
        pop_s      = 1'b0;
        bypass_s   = 1'b0;
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = {XLEN{1'b0}};
        if (!srst) begin
            rf_we_o = 1'b0;
        end else if (stall_s) begin
            pop_s      = 1'b1;
            rf_we_o    = 1'b1;
            rf_waddr_o = head_s.rd;
            rf_wdata_o = head_s.data;
        end else if (wb_act_s) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = wb_rd_i;
            rf_wdata_o = wb_result_i;
        end else if (!empty_s) begin
            pop_s      = 1'b1;
            rf_we_o    = 1'b1;
            rf_waddr_o = head_s.rd;
            rf_wdata_o = head_s.data;
        end else if (lu_valid_i && (lu_rd_i != 5'd0)) begin
            bypass_s   = 1'b1;
            rf_we_o    = 1'b1;
            rf_waddr_o = lu_rd_i;
            rf_wdata_o = lu_data_i;
        end else begin
            rf_we_o = 1'b0;
        end
    end

    // Results for x0 are accepted but never stored or written.
    assign lu_ready_o      = srst && (!full_s || pop_s);
    assign push_s          = lu_valid_i && lu_ready_o && (lu_rd_i != 5'd0) && !bypass_s;
    assign push_req_s.rd   = lu_rd_i;
    assign push_req_s.data = lu_data_i;

    wb_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_pend_fifo (
        .clk   (clk),
        .srst  (srst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_req_s),
        .head  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Starvation counter: counts cycles the current head was passed over.
    always_ff @(posedge clk) begin
        if (!srst) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (empty_s || pop_s) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (wait_cnt_r != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end
    end

    // Scoreboard next state: an issue to the same register overrides its clear.
    always_comb begin
        busy_nxt_s = busy_o;
        if (pop_s || bypass_s) begin
            busy_nxt_s = busy_nxt_s & ~reg_mask(rf_waddr_o);
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (lu_issue_i && (lu_issue_rd_i != 5'd0)) begin
            busy_nxt_s = busy_nxt_s | reg_mask(lu_issue_rd_i);
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!srst) begin
            busy_o <= 32'h0000_0000;
        end else begin
            busy_o <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, bypass, priority, starvation,
// full-queue pop+push, scoreboard and x0 handling.
module tb_wb_port_arbiter;

    logic        clk;
    logic        srst;
    logic        wb_reg_write_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_result_i;
    logic        lu_issue_i;
    logic [4:0]  lu_issue_rd_i;
    logic        lu_valid_i;
    logic [4:0]  lu_rd_i;
    logic [31:0] lu_data_i;
    logic        lu_ready_o;
    logic        wb_stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] busy_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    wb_port_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .clk            (clk),
        .srst           (srst),
        .wb_reg_write_i (wb_reg_write_i),
        .wb_rd_i        (wb_rd_i),
        .wb_result_i    (wb_result_i),
        .lu_issue_i     (lu_issue_i),
        .lu_issue_rd_i  (lu_issue_rd_i),
        .lu_valid_i     (lu_valid_i),
        .lu_rd_i        (lu_rd_i),
        .lu_data_i      (lu_data_i),
        .lu_ready_o     (lu_ready_o),
        .wb_stall_o     (wb_stall_o),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_reg_write_i = 1'b0;
        wb_rd_i        = 5'd0;
        wb_result_i    = 32'h0;
        lu_issue_i     = 1'b0;
        lu_issue_rd_i  = 5'd0;
        lu_valid_i     = 1'b0;
        lu_rd_i        = 5'd0;
        lu_data_i      = 32'h0;
    endtask

    task automatic wport(input logic we, input logic [4:0] a, input logic [31:0] d, input logic st);
        chk("rf_we", {63'd0, rf_we_o}, {63'd0, we});
        if (we) begin
            chk("rf_waddr", {59'd0, rf_waddr_o}, {59'd0, a});
            chk("rf_wdata", {32'd0, rf_wdata_o}, {32'd0, d});
        end
        chk("wb_stall", {63'd0, wb_stall_o}, {63'd0, st});
    endtask

    // W stage must never write a register with an LU write outstanding.
    always @(negedge clk) begin
        if (srst === 1'b1 && wb_reg_write_i === 1'b1 && wb_rd_i != 5'd0) begin
            chk_cnt++;
            assert (busy_o[wb_rd_i] === 1'b0) pass_cnt++;
            else begin
                fail_cnt++;
                $error("FAIL waw_hazard rd=%0d busy=%h", wb_rd_i, busy_o);
            end
        end
    end

    initial begin
        // 1: reset with every input active
        srst = 1'b0;
        wb_reg_write_i = 1'b1; wb_rd_i = 5'd3; wb_result_i = 32'h33;
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd4;
        lu_valid_i = 1'b1; lu_rd_i = 5'd5; lu_data_i = 32'h55;
        for (int i = 0; i < 3; i++) begin
            #2;
            wport(1'b0, 5'd0, 32'h0, 1'b0);
            chk("rst_lu_ready", {63'd0, lu_ready_o}, 64'd0);
            edge1();
        end
        chk("rst_busy", {32'd0, busy_o}, 64'd0);
        idle();
        srst = 1'b1;
        #2;
        wport(1'b0, 5'd0, 32'h0, 1'b0);
        chk("post_rst_ready", {63'd0, lu_ready_o}, 64'd1);

        // 2: bypass clears busy[5]
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd5;
        edge1();
        chk("busy5_set", {32'd0, busy_o}, 64'h20);
        idle();
        lu_valid_i = 1'b1; lu_rd_i = 5'd5; lu_data_i = 32'hDEAD_BEEF;
        #2;
        wport(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
        chk("bypass_ready", {63'd0, lu_ready_o}, 64'd1);
        edge1();
        idle();
        chk("busy5_clr", {32'd0, busy_o}, 64'h0);
        #2;
        wport(1'b0, 5'd0, 32'h0, 1'b0);

        // 3: W stage priority, LU results queue up
        wb_reg_write_i = 1'b1; wb_rd_i = 5'd3; wb_result_i = 32'h33;
        lu_valid_i = 1'b1; lu_rd_i = 5'd7; lu_data_i = 32'h11;
        #2;
        wport(1'b1, 5'd3, 32'h33, 1'b0);
        chk("q_ready1", {63'd0, lu_ready_o}, 64'd1);
        edge1();
        lu_rd_i = 5'd8; lu_data_i = 32'h22;
        #2;
        wport(1'b1, 5'd3, 32'h33, 1'b0);
        chk("q_ready2", {63'd0, lu_ready_o}, 64'd1);
        edge1();
        lu_rd_i = 5'd9; lu_data_i = 32'h99;
        #2;
        wport(1'b1, 5'd3, 32'h33, 1'b0);
        chk("q_ready3_full", {63'd0, lu_ready_o}, 64'd0);
        edge1();

        // 4: starvation - x7 passed over 4 cycles, stolen on the next
        lu_valid_i = 1'b0; lu_rd_i = 5'd0; lu_data_i = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #2;
            wport(1'b1, 5'd3, 32'h33, 1'b0);
            edge1();
        end
        #2;
        wport(1'b1, 5'd7, 32'h11, 1'b1);
        chk("stall_pop_ready", {63'd0, lu_ready_o}, 64'd1);
        edge1();
        for (int i = 0; i < 4; i++) begin
            #2;
            wport(1'b1, 5'd3, 32'h33, 1'b0);
            edge1();
        end
        #2;
        wport(1'b1, 5'd8, 32'h22, 1'b1);
        edge1();
        #2;
        wport(1'b1, 5'd3, 32'h33, 1'b0);
        idle();

        // 5: full queue, W idle: pop and push in the same cycle
        wb_reg_write_i = 1'b1; wb_rd_i = 5'd3; wb_result_i = 32'h33;
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd8;
        lu_valid_i = 1'b1; lu_rd_i = 5'd7; lu_data_i = 32'h11;
        edge1();
        lu_issue_i = 1'b0; lu_issue_rd_i = 5'd0;
        lu_rd_i = 5'd8; lu_data_i = 32'h22;
        edge1();
        chk("busy8_set", {32'd0, busy_o}, 64'h100);
        wb_reg_write_i = 1'b0; wb_rd_i = 5'd0;
        lu_rd_i = 5'd9; lu_data_i = 32'h99;
        #2;
        wport(1'b1, 5'd7, 32'h11, 1'b0);
        chk("full_popush_ready", {63'd0, lu_ready_o}, 64'd1);
        edge1();
        idle();
        #2;
        wport(1'b1, 5'd8, 32'h22, 1'b0);
        edge1();
        chk("busy8_clr", {32'd0, busy_o}, 64'h0);
        #2;
        wport(1'b1, 5'd9, 32'h99, 1'b0);
        edge1();
        #2;
        wport(1'b0, 5'd0, 32'h0, 1'b0);

        // 6: scoreboard set-wins, x0 issue, x0 writes
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd4;
        lu_valid_i = 1'b1; lu_rd_i = 5'd4; lu_data_i = 32'h44;
        #2;
        wport(1'b1, 5'd4, 32'h44, 1'b0);
        edge1();
        chk("busy4_set_wins", {32'd0, busy_o}, 64'h10);
        idle();
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd0;
        edge1();
        chk("busy_x0_issue", {32'd0, busy_o}, 64'h10);
        idle();
        wb_reg_write_i = 1'b1; wb_rd_i = 5'd0; wb_result_i = 32'hAA;
        #2;
        wport(1'b0, 5'd0, 32'h0, 1'b0);
        edge1();
        idle();
        lu_valid_i = 1'b1; lu_rd_i = 5'd4; lu_data_i = 32'h45;
        edge1();
        chk("busy4_clr", {32'd0, busy_o}, 64'h0);
        lu_rd_i = 5'd0; lu_data_i = 32'h77;
        #2;
        wport(1'b0, 5'd0, 32'h0, 1'b0);
        chk("x0_lu_ready", {63'd0, lu_ready_o}, 64'd1);
        edge1();
        idle();
        #2;
        wport(1'b0, 5'd0, 32'h0, 1'b0);

        // reset mid-run discards a queued entry
        wb_reg_write_i = 1'b1; wb_rd_i = 5'd3; wb_result_i = 32'h33;
        lu_valid_i = 1'b1; lu_rd_i = 5'd7; lu_data_i = 32'h11;
        edge1();
        idle();
        srst = 1'b0;
        edge1();
        srst = 1'b1;
        #2;
        wport(1'b0, 5'd0, 32'h0, 1'b0);
        edge1();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
